// File: rtl/hms_stopwatch.sv
// hms_stopwatch: hours/minutes/seconds stopwatch in packed BCD for the VGA
// time printer. A prescaler on the pixel clock produces the one-second tick.
// The printer sees a copy of the time that is reloaded once per frame.
module hms_stopwatch #(
    parameter int TICK_DIV  = 25000000,
    parameter bit VS_ACTIVE = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ss,
    input  logic       clr,
    input  logic       vs,
    output logic [7:0] th,
    output logic [7:0] tm,
    output logic [7:0] ts,
    output logic       running,
    output logic       tick
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    typedef enum logic {
        STOP = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [PW-1:0] pre;
    logic [PW-1:0] pre_next;
    logic [7:0]    cur_h;
    logic [7:0]    cur_m;
    logic [7:0]    cur_s;
    logic [7:0]    h_next;
    logic [7:0]    m_next;
    logic [7:0]    s_next;
    logic          tick_next;
    logic          ss_prev;
    logic          vs_prev;
    logic          rise;
    logic          frame;

    // Advance one packed-BCD field by one; the caller handles the field's wrap.
    function automatic logic [7:0] bcd_step(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Next-state logic: edge detection, prescaler, clear and the BCD carry chain.
    always_comb begin
        rise       = ss & ~ss_prev;
        frame      = (vs == VS_ACTIVE) && (vs_prev != VS_ACTIVE);
        state_next = state;
        pre_next   = pre;
        tick_next  = 1'b0;
        h_next     = cur_h;
        m_next     = cur_m;
        s_next     = cur_s;

        if (state == RUN) begin
            if (pre == PRE_MAX) begin
                pre_next  = '0;
                tick_next = 1'b1;
                s_next    = (cur_s == 8'h59) ? 8'h00 : bcd_step(cur_s);
                if (cur_s == 8'h59) begin
                    m_next = (cur_m == 8'h59) ? 8'h00 : bcd_step(cur_m);
                    if (cur_m == 8'h59)
                        h_next = (cur_h == 8'h23) ? 8'h00 : bcd_step(cur_h);
                end
            end else begin
                pre_next = pre + PW'(1);
            end
        end else if (clr) begin
            pre_next = '0;
            h_next   = 8'h00;
            m_next   = 8'h00;
            s_next   = 8'h00;
        end

        if (rise)
            state_next = (state == RUN) ? STOP : RUN;
    end

    // Run/stop state machine with registered running/tick, time registers and frame latch.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= STOP;
            running <= 1'b0;
            tick    <= 1'b0;
            pre     <= '0;
            cur_h   <= 8'h00;
            cur_m   <= 8'h00;
            cur_s   <= 8'h00;
            th      <= 8'h00;
            tm      <= 8'h00;
            ts      <= 8'h00;
            ss_prev <= 1'b0;
            vs_prev <= ~VS_ACTIVE;
        end else begin
            state   <= state_next;
            running <= (state_next == RUN);
            tick    <= tick_next;
            pre     <= pre_next;
            cur_h   <= h_next;
            cur_m   <= m_next;
            cur_s   <= s_next;
            ss_prev <= ss;
            vs_prev <= vs;
            if (frame) begin
                th <= h_next;
                tm <= m_next;
                ts <= s_next;
            end
        end
    end

endmodule

// File: tb/tb_hms_stopwatch.sv
// tb_hms_stopwatch: directed scenarios plus random run/stop/clear traffic,
// compared every cycle against a model that keeps time as a plain count of
// seconds since midnight.
module tb_hms_stopwatch;

    localparam int  TICK_DIV  = 4;
    localparam bit  VS_ACTIVE = 1'b0;
    localparam int  DAY       = 86400;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ss = 1'b0;
    logic       clr = 1'b0;
    logic       vs = 1'b1;
    logic [7:0] th;
    logic [7:0] tm;
    logic [7:0] ts;
    logic       running;
    logic       tick;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_secs = 0;
    int m_disp = 0;
    int m_pre  = 0;
    bit m_run  = 0;
    bit m_tick = 0;
    bit m_ssp  = 0;
    bit m_vsp  = 1;

    // Frame generator: vs active for 2 of every 10 cycles unless held off
    int fcnt    = 0;
    bit vs_hold = 0;

    hms_stopwatch #(.TICK_DIV(TICK_DIV), .VS_ACTIVE(VS_ACTIVE)) dut (
        .clk     (clk),
        .reset   (reset),
        .ss      (ss),
        .clr     (clr),
        .vs      (vs),
        .th      (th),
        .tm      (tm),
        .ts      (ts),
        .running (running),
        .tick    (tick)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] to_bcd(input int n);
        return 8'(((n / 10) << 4) | (n % 10));
    endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Model one clock edge from the rules: tick and increment, clear, toggle, latch.
    task automatic modelStep(input bit s, input bit c, input bit v);
        bit rise_m;
        bit frame_m;
        rise_m  = s && !m_ssp;
        frame_m = (v == VS_ACTIVE) && (m_vsp != VS_ACTIVE);
        m_tick  = 0;
        if (m_run) begin
            if (m_pre == TICK_DIV - 1) begin
                m_pre  = 0;
                m_tick = 1;
                m_secs = (m_secs + 1) % DAY;
            end else begin
                m_pre++;
            end
        end else if (c) begin
            m_pre  = 0;
            m_secs = 0;
        end
        if (rise_m)
            m_run = !m_run;
        if (frame_m)
            m_disp = m_secs;
        m_ssp = s;
        m_vsp = v;
    endtask

    task automatic compareAll();
        checkOutput("running", int'(running), int'(m_run));
        checkOutput("tick", int'(tick), int'(m_tick));
        checkOutput("th", int'(th), int'(to_bcd(m_disp / 3600)));
        checkOutput("tm", int'(tm), int'(to_bcd((m_disp / 60) % 60)));
        checkOutput("ts", int'(ts), int'(to_bcd(m_disp % 60)));
    endtask

    task automatic applyStimulus(input bit s, input bit c);
        bit v;
        v   = vs_hold ? ~VS_ACTIVE : (((fcnt % 10) < 2) ? VS_ACTIVE : ~VS_ACTIVE);
        fcnt++;
        ss  = s;
        clr = c;
        vs  = v;
        @(posedge clk);
        modelStep(s, c, v);
        #1;
        compareAll();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(0, 0);
    endtask

    task automatic pulseSs();
        applyStimulus(1, 0);
        applyStimulus(0, 0);
    endtask

    task automatic doReset();
        reset = 1'b0;
        ss    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vs = ~vs;
            @(posedge clk);
        end
        #1;
        m_secs = 0; m_disp = 0; m_pre = 0; m_run = 0; m_tick = 0;
        m_ssp  = 0; m_vsp  = ~VS_ACTIVE;
        checkOutput("rst_th", int'(th), 0);
        checkOutput("rst_tm", int'(tm), 0);
        checkOutput("rst_ts", int'(ts), 0);
        checkOutput("rst_running", int'(running), 0);
        checkOutput("rst_tick", int'(tick), 0);
        reset = 1'b1;
        ss    = 1'b0;
        vs    = ~VS_ACTIVE;
    endtask

    // Wait (bounded) until the prescaler has just reached the target value while running.
    task automatic waitPre(input int target);
        int n;
        n = 0;
        while (!(m_run && m_pre == target) && n < 4 * TICK_DIV) begin
            applyStimulus(0, 0);
            n++;
        end
        if (!(m_run && m_pre == target))
            checkOutput("wait_timeout", 0, 1);
    endtask

    task automatic ensureStopped();
        if (m_run)
            pulseSs();
    endtask

    task automatic ensureRunning();
        if (!m_run)
            pulseSs();
    endtask

    // Load the internal time while stopped, then run across the carry.
    task automatic rolloverFrom(input int p);
        ensureStopped();
        force dut.cur_h = to_bcd(p / 3600);
        force dut.cur_m = to_bcd((p / 60) % 60);
        force dut.cur_s = to_bcd(p % 60);
        m_secs = p;
        applyStimulus(0, 0);
        release dut.cur_h;
        release dut.cur_m;
        release dut.cur_s;
        pulseSs();
        idle(14);
        pulseSs();
        idle(12);
    endtask

    initial begin
        doReset();
        idle(3);

        // Start and count across ten seconds with regular frames
        applyStimulus(1, 0);
        applyStimulus(1, 0);
        applyStimulus(1, 0);
        idle(45);

        // Stop with the prescaler at 2, stay stopped, then resume
        waitPre(1);
        pulseSs();
        idle(20);
        pulseSs();
        idle(10);

        // clr while running is ignored
        for (int i = 0; i < 5; i++)
            applyStimulus(0, 1);

        // Stop, clear, and let a frame show the cleared time
        ensureStopped();
        applyStimulus(0, 1);
        applyStimulus(0, 1);
        idle(12);

        // clr together with rise while stopped: clear and start
        applyStimulus(1, 1);
        applyStimulus(0, 0);
        idle(12);

        // Carries: full day, hour and minute
        rolloverFrom(DAY - 1);
        rolloverFrom(3599);
        rolloverFrom(59);

        // Frame latch: no frames for five ticks, then frames resume
        ensureRunning();
        vs_hold = 1;
        idle(22);
        vs_hold = 0;
        fcnt    = 0;
        idle(12);

        // Rise on the terminal prescaler cycle: one increment then stop
        ensureRunning();
        waitPre(TICK_DIV - 1);
        applyStimulus(1, 0);
        checkOutput("sim_tick", int'(tick), 1);
        checkOutput("sim_running", int'(running), 0);
        idle(12);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 63) == 0)
                vs_hold = ~vs_hold;
            applyStimulus($urandom_range(0, 11) == 0, $urandom_range(0, 7) == 0);
        end
        vs_hold = 0;
        idle(12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
